// File: rtl/cic_interpolator.sv
// CIC interpolator: Q comb stages at the input rate, zero-stuffing by R, Q integrators
// at the output rate (paced by ce_out), and an arithmetic shift that brings DC gain to unity.
module cic_interpolator #(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 3,
  parameter int R          = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce_out,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         underflow
);

  localparam int LOG2_R = $clog2(R);
  localparam int W      = DATA_WIDTH + Q * LOG2_R;
  localparam int S      = (Q - 1) * LOG2_R;
  localparam int PW     = (LOG2_R > 0) ? LOG2_R : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16) || Q < 1 || Q > 6) begin : g_bad_param
      $error("cic_interpolator: R must be 1/2/4/8/16 and Q must be 1..6");
    end
  endgenerate

  logic [PW-1:0]                phase;
  logic signed [DATA_WIDTH-1:0] hold_buf;
  logic                         hold_valid;
  logic signed [W-1:0]          comb_d  [Q];
  logic signed [W-1:0]          comb_in [Q];
  logic signed [W-1:0]          integ   [Q];
  logic signed [W-1:0]          u;

  logic phase_zero;
  logic consume;
  logic advance;
  logic starve;
  logic load;

  // Handshake: x_in transfers on a cycle where in_valid && in_ready. A source that sees
  // in_ready low keeps in_valid and x_in stable until the transfer happens.
  assign phase_zero = (phase == '0);
  assign in_ready   = !hold_valid || (ce_out && phase_zero);
  assign load       = in_valid && in_ready;
  assign consume    = ce_out && phase_zero && hold_valid;
  assign advance    = ce_out && (!phase_zero || hold_valid);
  assign starve     = ce_out && phase_zero && !hold_valid;

  // Comb chain evaluated combinationally; comb_in[k] is the value stage k+1 stores.
  always_comb begin
    logic signed [W-1:0] acc;
    acc = W'(hold_buf);
    for (int k = 0; k < Q; k++) begin
      comb_in[k] = acc;
      acc        = acc - comb_d[k];
    end
    u = consume ? acc : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      hold_buf   <= '0;
      hold_valid <= 1'b0;
      x_out      <= '0;
      out_valid  <= 1'b0;
      underflow  <= 1'b0;
      for (int k = 0; k < Q; k++) begin
        comb_d[k] <= '0;
        integ[k]  <= '0;
      end
    end else begin
      out_valid <= advance;
      underflow <= starve;

      if (load) begin
        hold_buf   <= x_in;
        hold_valid <= 1'b1;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end

      if (consume) begin
        for (int k = 0; k < Q; k++) begin
          comb_d[k] <= comb_in[k];
        end
      end

      // Integrators wrap modulo 2^W; the final difference is still exact.
      if (advance) begin
        phase    <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        integ[0] <= integ[0] + u;
        for (int k = 1; k < Q; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        x_out <= DATA_WIDTH'(integ[Q-1] >>> S);
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: R=4/Q=3 and R=1/Q=3 instances checked against an impulse-response
// model (upsampled input convolved with Q cascaded length-R boxcars), plus directed corner cases.
module tb_cic_interpolator;

  localparam int DW = 16;
  localparam int QA = 3;
  localparam int RA = 4;
  localparam int SA = 4;
  localparam int RB = 1;
  localparam int SB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic                 ce_a, in_valid_a, in_ready_a, out_valid_a, underflow_a;
  logic signed [DW-1:0] x_in_a, x_out_a;
  logic                 ce_b, in_valid_b, in_ready_b, out_valid_b, underflow_b;
  logic signed [DW-1:0] x_in_b, x_out_b;

  cic_interpolator #(.DATA_WIDTH(DW), .Q(QA), .R(RA)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce_out(ce_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .x_in(x_in_a),
    .out_valid(out_valid_a), .x_out(x_out_a), .underflow(underflow_a)
  );

  cic_interpolator #(.DATA_WIDTH(DW), .Q(QA), .R(RB)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce_out(ce_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .x_in(x_in_b),
    .out_valid(out_valid_b), .x_out(x_out_b), .underflow(underflow_b)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] in_q_a[$];
  logic [DW-1:0] in_q_b[$];
  int  out_cnt_a, out_cnt_b, uf_cnt_a, uf_cnt_b;
  bit  acc_a, acc_b;
  bit  ce_a_rand, ce_a_fix, ce_b_en, ce_prev_b;
  int  cyc_b;
  bit  const_on, tbl_on;
  int  const_val;

  typedef struct {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of ways to write j as a sum of q terms each in 0..r-1 = tap j of q cascaded boxcars.
  function automatic longint box_coef(input int r, input int q, input int j);
    longint s;
    if (j < 0) return 0;
    if (q == 0) return (j == 0) ? 1 : 0;
    s = 0;
    for (int t = 0; t < r; t++) s += box_coef(r, q - 1, j - t);
    return s;
  endfunction

  // Output for advancing tick m: full-precision CIC result at m-Q, shifted by S, truncated.
  function automatic logic [DW-1:0] model_out(input bit which, input int m);
    int     r, s, n, sz, j;
    longint acc;
    logic [DW-1:0] xv;
    r = which ? RB : RA;
    s = which ? SB : SA;
    n = m - QA;
    if (n < 0) return '0;
    acc = 0;
    sz  = which ? in_q_b.size() : in_q_a.size();
    for (int k = 0; k < sz; k++) begin
      j = n - k * r;
      if (j < 0) break;
      xv = which ? in_q_b[k] : in_q_a[k];
      acc += longint'($signed(xv)) * box_coef(r, QA, j);
    end
    return DW'(acc >>> s);
  endfunction

  task automatic monitor();
    if (!rst_n) begin
      in_q_a.delete(); in_q_b.delete();
      out_cnt_a = 0; out_cnt_b = 0; uf_cnt_a = 0; uf_cnt_b = 0;
      acc_a = 0; acc_b = 0; ce_prev_b = 0;
    end else begin
      acc_a = in_valid_a && in_ready_a;
      if (acc_a) in_q_a.push_back(x_in_a);
      if (out_valid_a) begin
        check("x_out_a", $signed(x_out_a), $signed(model_out(1'b0, out_cnt_a)));
        if (const_on && out_cnt_a >= 16) check("settle_a", $signed(x_out_a), const_val);
        out_cnt_a++;
      end
      if (underflow_a) uf_cnt_a++;

      acc_b = in_valid_b && in_ready_b;
      if (acc_b) in_q_b.push_back(x_in_b);
      if (out_valid_b) begin
        check("x_out_b", $signed(x_out_b), $signed(model_out(1'b1, out_cnt_b)));
        check("ce_gate_b", ce_prev_b, 1);
        if (tbl_on && out_cnt_b < 10) check("tbl_b", $signed(x_out_b), tbl[out_cnt_b].exp);
        out_cnt_b++;
      end
      if (underflow_b) uf_cnt_b++;
      ce_prev_b = ce_b;
    end
  endtask

  // One clock: sample at the falling edge, then update ce strobes just after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    ce_a = ce_a_rand ? ($urandom_range(0, 9) < 7) : ce_a_fix;
    cyc_b++;
    ce_b = ce_b_en && (cyc_b % 3 == 0);
  endtask

  task automatic send_a(input logic signed [DW-1:0] v);
    in_valid_a = 1'b1;
    x_in_a     = v;
    for (int i = 0; i < 200; i++) begin
      step();
      if (acc_a) begin
        in_valid_a = 1'b0;
        return;
      end
    end
    check("send_a_timeout", 0, 1);
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic signed [DW-1:0] v);
    in_valid_b = 1'b1;
    x_in_b     = v;
    for (int i = 0; i < 200; i++) begin
      step();
      if (acc_b) begin
        in_valid_b = 1'b0;
        return;
      end
    end
    check("send_b_timeout", 0, 1);
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_row(input int i, input int x, input int e);
    tbl[i].x   = x[DW-1:0];
    tbl[i].exp = e[DW-1:0];
  endtask

  int uf_mid;

  initial begin
    rst_n = 1'b0;
    ce_a = 0; ce_b = 0; ce_a_fix = 0; ce_a_rand = 0; ce_b_en = 0; cyc_b = 0;
    in_valid_a = 0; in_valid_b = 0; x_in_a = '0; x_in_b = '0;
    const_on = 0; tbl_on = 0; const_val = 0;

    set_row(0, 100, 0);      set_row(1, -200, 0);   set_row(2, 300, 0);
    set_row(3, 32767, 100);  set_row(4, -32768, -200);
    set_row(5, 5, 300);      set_row(6, -1, 32767);  set_row(7, 77, -32768);
    set_row(8, 1234, 5);     set_row(9, -999, -1);

    // Reset state, then idle with ce low.
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready_a", in_ready_a, 1);
    check("rst_out_valid_a", out_valid_a, 0);
    check("rst_x_out_a", x_out_a, 0);
    check("rst_underflow_a", underflow_a, 0);
    check("rst_in_ready_b", in_ready_b, 1);
    check("rst_x_out_b", x_out_b, 0);

    // A tick with an empty buffer pulses underflow and produces no output.
    ce_a_fix = 1;
    step();
    step();
    check("idle_underflow_a", underflow_a, 1);
    check("idle_out_valid_a", out_valid_a, 0);

    // Constant inputs settle to the input value exactly.
    const_val = 1000; const_on = 1;
    do_reset();
    for (int i = 0; i < 30; i++) send_a(16'sd1000);
    drain(40);
    check("const1000_count", out_cnt_a, 120);

    const_val = -32768;
    do_reset();
    for (int i = 0; i < 20; i++) send_a(16'sh8000);
    drain(40);
    check("const_neg_count", out_cnt_a, 80);

    const_val = 32767;
    do_reset();
    for (int i = 0; i < 20; i++) send_a(16'sh7fff);
    drain(40);
    check("const_pos_count", out_cnt_a, 80);
    const_on = 0;

    // Ratio: ten samples give exactly forty outputs, then the block starves.
    do_reset();
    for (int i = 0; i < 10; i++) send_a(DW'($urandom));
    drain(40);
    check("ratio_count", out_cnt_a, 40);
    check("ratio_starved", uf_cnt_a > 0, 1);

    // Stall across a phase-0 tick; model output is indexed by advancing tick so gaps are invisible.
    do_reset();
    for (int i = 0; i < 6; i++) send_a(DW'(i * 3000 - 9000));
    uf_mid = uf_cnt_a;
    drain(10);
    check("stall_underflow", uf_cnt_a > uf_mid, 1);
    for (int i = 0; i < 6; i++) send_a(DW'(i * -2500 + 4000));
    drain(40);
    check("stall_count", out_cnt_a, 48);

    // Random data, random source gaps, random ce_out.
    do_reset();
    ce_a_rand = 1;
    for (int i = 0; i < 40; i++) begin
      send_a(DW'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    ce_a_rand = 0;
    drain(80);
    check("random_count", out_cnt_a, 160);

    // Reset in the middle of a stream clears everything; nothing emerges until new input.
    do_reset();
    for (int i = 0; i < 25; i++) send_a(16'sd1234);
    check("pre_reset_x_out", $signed(x_out_a), 1234);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x_out", x_out_a, 0);
    check("mid_rst_out_valid", out_valid_a, 0);
    check("mid_rst_in_ready", in_ready_a, 1);
    step();
    rst_n = 1'b1;
    check("post_rst_underflow", underflow_a, 0);
    check("post_rst_x_out", x_out_a, 0);
    drain(20);
    check("post_rst_no_output", out_cnt_a, 0);
    for (int i = 0; i < 5; i++) send_a(16'sd1234);
    drain(20);
    check("post_rst_count", out_cnt_a, 20);

    // R=1: every tick consumes; output is the input delayed by Q ticks; ce_out every third cycle.
    ce_a_fix = 0;
    do_reset();
    ce_b_en = 1;
    tbl_on  = 1;
    for (int i = 0; i < 10; i++) send_b(tbl[i].x);
    for (int i = 0; i < 20; i++) send_b(DW'($urandom));
    drain(30);
    check("r1_count", out_cnt_b, 30);
    check("r1_starved", uf_cnt_b > 0, 1);
    tbl_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
